// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port controller: default port width,
// register offsets (addr[4:2]) and the register-select enum used by the
// bus decoder.
package gpio_pkg;

    localparam int GPIO_WIDTH = 8;

    localparam logic [2:0] GPIO_DIR_OFF = 3'd0;
    localparam logic [2:0] GPIO_OUT_OFF = 3'd1;
    localparam logic [2:0] GPIO_IN_OFF  = 3'd2;
    localparam logic [2:0] GPIO_IE_OFF  = 3'd3;
    localparam logic [2:0] GPIO_IS_OFF  = 3'd4;
    localparam logic [2:0] GPIO_POL_OFF = 3'd5;

    typedef enum logic [2:0] {
        REG_DIR  = GPIO_DIR_OFF,
        REG_OUT  = GPIO_OUT_OFF,
        REG_IN   = GPIO_IN_OFF,
        REG_IE   = GPIO_IE_OFF,
        REG_IS   = GPIO_IS_OFF,
        REG_POL  = GPIO_POL_OFF,
        REG_RSV6 = 3'd6,
        REG_RSV7 = 3'd7
    } gpio_reg_e;

endpackage

// File: rtl/gpio_port_ctrl_if.sv
// Single-cycle request/ack register bus between the peripheral
// interconnect (master) and one GPIO port controller (slave).
import gpio_pkg::*;

interface gpio_port_ctrl_if #(
    parameter int WIDTH = GPIO_WIDTH
);
    logic             req_i;
    logic             we_i;
    logic [4:0]       addr_i;
    logic [WIDTH-1:0] wdata_i;
    logic [WIDTH-1:0] rdata_o;
    logic             ack_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ack_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ack_o
    );
endinterface

// File: rtl/gpio_sync_deb.sv
// One-pin input conditioner: SYNC_STAGES-deep synchronizer, optionally
// followed by a stable-count debouncer when GPIO_PORT_DEBOUNCE_EN is
// defined. Without the macro the synchronizer output is passed straight out
// and no counter exists.
module gpio_sync_deb #(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_PORT_DEBOUNCE_EN
    , parameter int DEB_CYCLES = 16
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    output logic in_o
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift the asynchronous pad value through the metastability chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pad_i};
        end
    end

`ifdef GPIO_PORT_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             deb_r;

    // Accept a new level only after it has differed from the held value for
    // DEB_CYCLES consecutive clocks; any return to the held value restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            deb_r <= 1'b0;
        end else if (sync_r[SYNC_STAGES-1] != deb_r) begin
            if (cnt_r == CNT_LAST) begin
                deb_r <= sync_r[SYNC_STAGES-1];
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign in_o = deb_r;
`else
    assign in_o = sync_r[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/gpio_port_ctrl.sv
// Device-side controller for one bidirectional GPIO port: DIR/OUT/IE/POL
// registers, synchronized pad input, per-pin edge detection into RW1C
// pending bits and a registered port interrupt. Optional input debounce is
// enabled with the GPIO_PORT_DEBOUNCE_EN macro.
import gpio_pkg::*;

module gpio_port_ctrl #(
    parameter int WIDTH       = GPIO_WIDTH,
    parameter int SYNC_STAGES = 2
`ifdef GPIO_PORT_DEBOUNCE_EN
    , parameter int DEB_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    gpio_port_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0]  pad_in_i,
    output logic [WIDTH-1:0]  pad_out_o,
    output logic [WIDTH-1:0]  pad_oe_o,
    output logic              irq_o
);

    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] ie_r;
    logic [WIDTH-1:0] is_r;
    logic [WIDTH-1:0] pol_r;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] rdata_r;
    logic             ack_r;
    logic             irq_r;

    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] rd_mux_s;
    logic [WIDTH-1:0] w1c_s;
    logic [WIDTH-1:0] evt_s;
    logic             wr_en_s;
    gpio_reg_e        reg_sel_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_sync_deb #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef GPIO_PORT_DEBOUNCE_EN
            , .DEB_CYCLES (DEB_CYCLES)
`endif
        ) u_sync_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .pad_i (pad_in_i[i]),
            .in_o  (in_s[i])
        );
    end

    assign reg_sel_s = gpio_reg_e'(bus.addr_i[4:2]);
    assign wr_en_s   = bus.req_i & bus.we_i;

    // A pin's event is its rising edge when POL=1, falling edge when POL=0.
    assign evt_s = (pol_r & in_s & ~prev_r) | (~pol_r & ~in_s & prev_r);

    // Read data selection; reserved offsets read as zero.
    always_comb begin
        rd_mux_s = {WIDTH{1'b0}};
        case (reg_sel_s)
            REG_DIR: rd_mux_s = dir_r;
            REG_OUT: rd_mux_s = out_r;
            REG_IN:  rd_mux_s = in_s;
            REG_IE:  rd_mux_s = ie_r;
            REG_IS:  rd_mux_s = is_r;
            REG_POL: rd_mux_s = pol_r;
            default: rd_mux_s = {WIDTH{1'b0}};
        endcase
    end

    // Write-one-to-clear mask for the pending register.
    always_comb begin
        if (wr_en_s && (reg_sel_s == REG_IS)) begin
            w1c_s = bus.wdata_i;
        end else begin
            w1c_s = {WIDTH{1'b0}};
        end
    end

    // Bus response, register writes, edge history, pending bits and irq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_r   <= {WIDTH{1'b0}};
            out_r   <= {WIDTH{1'b0}};
            ie_r    <= {WIDTH{1'b0}};
            is_r    <= {WIDTH{1'b0}};
            pol_r   <= {WIDTH{1'b0}};
            prev_r  <= {WIDTH{1'b0}};
            rdata_r <= {WIDTH{1'b0}};
            ack_r   <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            ack_r   <= bus.req_i;
            rdata_r <= (bus.req_i && !bus.we_i) ? rd_mux_s : {WIDTH{1'b0}};
            prev_r  <= in_s;
            // A new event outranks a clear of the same bit.
            is_r    <= (is_r & ~w1c_s) | evt_s;
            irq_r   <= |(is_r & ie_r);
            if (wr_en_s) begin
                case (reg_sel_s)
                    REG_DIR: dir_r <= bus.wdata_i;
                    REG_OUT: out_r <= bus.wdata_i;
                    REG_IE:  ie_r  <= bus.wdata_i;
                    REG_POL: pol_r <= bus.wdata_i;
                    default: dir_r <= dir_r;
                endcase
            end
        end
    end

    assign bus.ack_o   = ack_r;
    assign bus.rdata_o = rdata_r;
    assign pad_out_o   = out_r;
    assign pad_oe_o    = dir_r;
    assign irq_o       = irq_r;

endmodule
